// File: rtl/sobel_pkg.sv
// sobel_pkg: shared FSM encoding, default geometry and pixel arithmetic helpers
package sobel_pkg;
  typedef enum logic [1:0] {IDLE, FILL, STREAM, FLUSH} state_t;
  localparam int DEF_WIDTH = 768;
  localparam int DEF_HEIGHT = 512;
  function automatic logic [7:0] gray8(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    logic [9:0] s;
    s = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};
    return 8'(s >> 2);
  endfunction
  function automatic logic [7:0] sat_mag(input logic signed [10:0] gx, input logic signed [10:0] gy);
    logic [10:0] ax, ay;
    logic [11:0] s;
    ax = gx[10] ? 11'(-gx) : 11'(gx);
    ay = gy[10] ? 11'(-gy) : 11'(gy);
    s = {1'b0, ax} + {1'b0, ay};
    return s > 12'd255 ? 8'hff : s[7:0];
  endfunction
endpackage

// File: rtl/sobel_line_buf.sv
// sobel_line_buf: enable-gated circular RAM delaying its input by DEPTH accepted samples
module sobel_line_buf #(
  parameter int DEPTH = 768
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] din,
  output logic [7:0] dout
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] ptr_q, ptr_d;
  assign dout = mem[ptr_q];
  // read-before-write slot pointer, advancing only on accepted samples
  always_comb ptr_d = !en ? ptr_q : ptr_q == AW'(DEPTH - 1) ? '0 : ptr_q + 1'b1;
  // contents are never cleared; the fill phase overwrites them before use
  always_ff @(posedge clk) begin
    if (en) mem[ptr_q] <= din;
    ptr_q <= rst ? '0 : ptr_d;
  end
endmodule

// File: rtl/sobel_stream.sv
// sobel_stream: streaming RGB-to-gray Sobel edge detector with per-frame fill/flush control
module sobel_stream
  import sobel_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int THRESH = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_r,
  input  logic [7:0] in_g,
  input  logic [7:0] in_b,
  output logic       out_valid,
  output logic [7:0] out_r,
  output logic [7:0] out_g,
  output logic [7:0] out_b,
  output logic       out_last
);
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam logic [7:0] TH = 8'(THRESH);
  state_t state_q, state_d;
  logic [XW-1:0] x_q, x_d, cx_q, cx_d;
  logic [YW-1:0] y_q, y_d, cy_q, cy_d;
  logic [7:0] w_q [3][3];
  logic [7:0] w_d [3][3];
  logic v0_q, v0_d, bord0_q, bord0_d, last0_q, last0_d;
  logic v1_q, v1_d, bord1_q, bord1_d, last1_q, last1_d;
  logic signed [10:0] gx1_q, gx1_d, gy1_q, gy1_d;
  logic ready_q, ready_d, ov_q, ov_d, ol_q, ol_d;
  logic [7:0] pix_q, pix_d, mag, gray, lb0_o, lb1_o;
  logic acc, issue, x_end, y_end, cx_end, cy_end;
  assign acc = in_valid && ready_q;
  assign issue = (state_q == STREAM && acc) || state_q == FLUSH;
  assign x_end = x_q == XW'(WIDTH - 1);
  assign y_end = y_q == YW'(HEIGHT - 1);
  assign cx_end = cx_q == XW'(WIDTH - 1);
  assign cy_end = cy_q == YW'(HEIGHT - 1);
  assign gray = gray8(in_r, in_g, in_b);
  assign mag = sat_mag(gx1_q, gy1_q);
  assign in_ready = ready_q;
  assign out_valid = ov_q;
  assign out_r = pix_q;
  assign out_g = pix_q;
  assign out_b = pix_q;
  assign out_last = ol_q;
  sobel_line_buf #(.DEPTH(WIDTH)) u_lb0 (.clk(clk), .rst(rst), .en(acc), .din(gray), .dout(lb0_o));
  sobel_line_buf #(.DEPTH(WIDTH)) u_lb1 (.clk(clk), .rst(rst), .en(acc), .din(lb0_o), .dout(lb1_o));
  // next state: input/centre counters, FSM, window shift and the two gradient stages
  always_comb begin
    x_d = !acc ? x_q : x_end ? '0 : x_q + 1'b1;
    y_d = !(acc && x_end) ? y_q : y_end ? '0 : y_q + 1'b1;
    cx_d = !issue ? cx_q : cx_end ? '0 : cx_q + 1'b1;
    cy_d = !(issue && cx_end) ? cy_q : cy_end ? '0 : cy_q + 1'b1;
    state_d = state_q == IDLE && acc ? FILL :
              state_q == FILL && acc && x_q == '0 && y_q == YW'(1) ? STREAM :
              state_q == STREAM && acc && x_end && y_end ? FLUSH :
              state_q == FLUSH && cx_end && cy_end ? IDLE : state_q;
    ready_d = state_d != FLUSH;
    for (int r = 0; r < 3; r++) begin
      w_d[r][0] = acc ? w_q[r][1] : w_q[r][0];
      w_d[r][1] = acc ? w_q[r][2] : w_q[r][1];
    end
    w_d[0][2] = acc ? lb1_o : w_q[0][2];
    w_d[1][2] = acc ? lb0_o : w_q[1][2];
    w_d[2][2] = acc ? gray : w_q[2][2];
    v0_d = issue;
    bord0_d = cx_q == '0 || cx_end || cy_q == '0 || cy_end;
    last0_d = issue && cx_end && cy_end;
    v1_d = v0_q;
    bord1_d = bord0_q;
    last1_d = last0_q;
    gx1_d = $signed(11'(w_q[0][2]) + 11'({w_q[1][2], 1'b0}) + 11'(w_q[2][2])) -
            $signed(11'(w_q[0][0]) + 11'({w_q[1][0], 1'b0}) + 11'(w_q[2][0]));
    gy1_d = $signed(11'(w_q[2][0]) + 11'({w_q[2][1], 1'b0}) + 11'(w_q[2][2])) -
            $signed(11'(w_q[0][0]) + 11'({w_q[0][1], 1'b0}) + 11'(w_q[0][2]));
    ov_d = v1_q;
    ol_d = v1_q && last1_q;
    pix_d = v1_q && !bord1_q ? (THRESH == 0 ? mag : mag >= TH ? 8'hff : 8'h00) : 8'h00;
  end
  // datapath registers hold freely; control, counters and valids clear on reset
  always_ff @(posedge clk) begin
    w_q <= w_d;
    gx1_q <= gx1_d;
    gy1_q <= gy1_d;
    bord0_q <= bord0_d;
    bord1_q <= bord1_d;
    last0_q <= last0_d;
    last1_q <= last1_d;
    if (rst) begin
      state_q <= IDLE;
      x_q <= '0;
      y_q <= '0;
      cx_q <= '0;
      cy_q <= '0;
      v0_q <= 1'b0;
      v1_q <= 1'b0;
      ready_q <= 1'b1;
      ov_q <= 1'b0;
      ol_q <= 1'b0;
      pix_q <= '0;
    end else begin
      state_q <= state_d;
      x_q <= x_d;
      y_q <= y_d;
      cx_q <= cx_d;
      cy_q <= cy_d;
      v0_q <= v0_d;
      v1_q <= v1_d;
      ready_q <= ready_d;
      ov_q <= ov_d;
      ol_q <= ol_d;
      pix_q <= pix_d;
    end
  end
endmodule

// File: tb/tb_sobel_stream.sv
// tb_sobel_stream: scoreboard bench for sobel_stream at 8x6 with thresholds 0, 100 and 80
module tb_sobel_stream;
  localparam int W = 8;
  localparam int H = 6;
  localparam int N = W * H;
  typedef struct packed {
    logic            last;
    logic [2:0][7:0] v;
  } exp_t;
  typedef struct {
    int kind;
    int gap;
    int nz0;
    int nz100;
    int nz80;
    int sum0;
  } vec_t;
  int th [3] = '{0, 100, 80};
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic [7:0] in_r = '0, in_g = '0, in_b = '0;
  logic [2:0] rdy, ov, ol;
  logic [7:0] orr [3];
  logic [7:0] og [3];
  logic [7:0] ob [3];
  logic [7:0] fr_r [N];
  logic [7:0] fr_g [N];
  logic [7:0] fr_b [N];
  exp_t q [$];
  exp_t me;
  vec_t tbl [5];
  int checks = 0, errors = 0;
  int n_out, nlast, nrdy, sum0;
  int nz [3];

  sobel_stream #(.WIDTH(W), .HEIGHT(H), .THRESH(0)) u_t0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]), .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .out_valid(ov[0]), .out_r(orr[0]), .out_g(og[0]), .out_b(ob[0]), .out_last(ol[0]));
  sobel_stream #(.WIDTH(W), .HEIGHT(H), .THRESH(100)) u_t100 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]), .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .out_valid(ov[1]), .out_r(orr[1]), .out_g(og[1]), .out_b(ob[1]), .out_last(ol[1]));
  sobel_stream #(.WIDTH(W), .HEIGHT(H), .THRESH(80)) u_t80 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]), .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .out_valid(ov[2]), .out_r(orr[2]), .out_g(og[2]), .out_b(ob[2]), .out_last(ol[2]));

  always #5 clk = ~clk;

  function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // scoreboard: every emitted pixel on all three instances against the model queue
  always @(negedge clk) begin
    if (!rst) begin
      if (!rdy[0]) nrdy++;
      if (ov != 3'b000) begin
        n_out++;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: out_valid=%b with no pixel expected", ov);
        end else begin
          me = q.pop_front();
          for (int i = 0; i < 3; i++) begin
            check($sformatf("pixel_t%0d_k%0d", th[i], n_out - 1), {ov[i], ol[i], orr[i], og[i], ob[i]},
                  {1'b1, me.last, me.v[i], me.v[i], me.v[i]});
            if (orr[i] != 0) nz[i]++;
          end
          sum0 += int'(orr[0]);
          if (ol[0]) nlast++;
        end
      end
    end
  end

  task automatic set_px(input int i, input int r, input int g, input int b);
    fr_r[i] = 8'(r);
    fr_g[i] = 8'(g);
    fr_b[i] = 8'(b);
  endtask

  // kinds: 0 uniform 100, 1 step 0/255 at column 4, 2 step 40/60, otherwise random
  task automatic fill_frame(input int kind);
    for (int i = 0; i < N; i++) begin
      int x = i % W;
      case (kind)
        0: set_px(i, 100, 100, 100);
        1: set_px(i, x < 4 ? 0 : 255, x < 4 ? 0 : 255, x < 4 ? 0 : 255);
        2: set_px(i, x < 4 ? 40 : 60, x < 4 ? 40 : 60, x < 4 ? 40 : 60);
        default: set_px(i, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
      endcase
    end
  endtask

  // reference: whole-frame gray image, Sobel on interior centres, zero border
  task automatic push_exp(input int n);
    int g [H][W];
    int gx, gy, m;
    exp_t e;
    for (int i = 0; i < N; i++) g[i / W][i % W] = (int'(fr_r[i]) + 2 * int'(fr_g[i]) + int'(fr_b[i])) / 4;
    for (int i = 0; i < n; i++) begin
      int y = i / W;
      int x = i % W;
      m = 0;
      if (x > 0 && x < W - 1 && y > 0 && y < H - 1) begin
        gx = (g[y-1][x+1] + 2 * g[y][x+1] + g[y+1][x+1]) - (g[y-1][x-1] + 2 * g[y][x-1] + g[y+1][x-1]);
        gy = (g[y+1][x-1] + 2 * g[y+1][x] + g[y+1][x+1]) - (g[y-1][x-1] + 2 * g[y-1][x] + g[y-1][x+1]);
        m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        if (m > 255) m = 255;
      end
      e.last = (i == N - 1);
      for (int t = 0; t < 3; t++) e.v[t] = th[t] == 0 ? 8'(m) : (m >= th[t] ? 8'd255 : 8'd0);
      q.push_back(e);
    end
  endtask

  task automatic put(input int i, input int idle);
    int n = 0;
    in_valid = 1'b0;
    repeat (idle) @(negedge clk);
    in_r = fr_r[i];
    in_g = fr_g[i];
    in_b = fr_b[i];
    in_valid = 1'b1;
    while (!rdy[0] && n < 100) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("put_ready_px%0d", i), rdy[0], 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send(input int gap);
    for (int i = 0; i < N; i++) put(i, gap == 0 ? 0 : gap == 1 ? 1 : int'($urandom_range(0, 2)));
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic clr();
    n_out = 0;
    nlast = 0;
    nrdy = 0;
    sum0 = 0;
    nz = '{0, 0, 0};
  endtask

  task automatic frame_checks(input int nf);
    check("out_count", n_out, N * nf);
    check("last_count", nlast, nf);
    check("flush_ready_low", nrdy, 9 * nf);
  endtask

  task automatic chk_reset();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_valid%0d", i), ov[i], 0);
      check($sformatf("rst_last%0d", i), ol[i], 0);
      check($sformatf("rst_pix%0d", i), {orr[i], og[i], ob[i]}, 0);
      check($sformatf("rst_ready%0d", i), rdy[i], 1);
    end
  endtask

  initial begin
    tbl[0] = '{0, 0, 0, 0, 0, 0};
    tbl[1] = '{1, 0, 8, 8, 8, 2040};
    tbl[2] = '{2, 0, 8, 0, 8, 640};
    tbl[3] = '{1, 1, 8, 8, 8, 2040};
    tbl[4] = '{2, 1, 8, 0, 8, 640};
    clr();
    repeat (3) @(negedge clk);
    chk_reset();
    rst = 1'b0;
    @(negedge clk);
    for (int t = 0; t < 5; t++) begin
      fill_frame(tbl[t].kind);
      push_exp(N);
      clr();
      send(tbl[t].gap);
      drain();
      frame_checks(1);
      check($sformatf("tbl%0d_nz_t0", t), nz[0], tbl[t].nz0);
      check($sformatf("tbl%0d_nz_t100", t), nz[1], tbl[t].nz100);
      check($sformatf("tbl%0d_nz_t80", t), nz[2], tbl[t].nz80);
      check($sformatf("tbl%0d_sum_t0", t), sum0, tbl[t].sum0);
    end
    for (int f = 0; f < 4; f++) begin
      fill_frame(3);
      push_exp(N);
      clr();
      send(2);
      drain();
      frame_checks(1);
    end
    fill_frame(1);
    push_exp(N);
    clr();
    for (int i = 0; i <= W + 1; i++) put(i, 0);
    check("lat_edge0", ov, 3'b000);
    @(negedge clk);
    check("lat_edge1", ov, 3'b000);
    @(negedge clk);
    check("lat_edge2", ov, 3'b111);
    for (int i = W + 2; i < N; i++) put(i, 0);
    drain();
    frame_checks(1);
    fill_frame(1);
    push_exp(11);
    clr();
    for (int i = 0; i < 20; i++) put(i, 0);
    repeat (4) @(negedge clk);
    check("pre_rst_outputs", n_out, 11);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset();
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("abandoned_none", n_out, 11);
    fill_frame(0);
    push_exp(N);
    clr();
    send(0);
    drain();
    frame_checks(1);
    check("post_rst_nz", nz[0], 0);
    fill_frame(1);
    push_exp(N);
    push_exp(N);
    clr();
    send(0);
    send(0);
    drain();
    frame_checks(2);
    check("b2b_nz_t0", nz[0], 16);
    check("b2b_nz_t80", nz[2], 16);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
